// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier with a valid/ready
// stream interface and a single global stall.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready = ~stall)
//   a, b                 operands {sign, exp[EXP_W], frac[MAN_W]}
//   out_valid/out_ready  result handshake
//   out                  product
//   flags                {invalid, overflow, underflow, inexact}, aligned with out
//
// Stages: S1 unpack/classify/exponent sum, S2 mantissa product,
//         S3 normalise/round/range-check/pack (output register).
// Subnormal inputs are treated as zero; underflowing results flush to zero.
//
// Optional macro FP_MULT_RNE_EN: when defined, round-to-nearest-even and
// overflow to infinity. When undefined (default), truncation and overflow
// saturates to the largest finite magnitude.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [3:0]   flags
);
    localparam int STAGES = 3;
    localparam int EW     = EXP_W + 2;       // signed exponent width inside the pipe
    localparam int PW     = 2 * MAN_W + 2;   // mantissa product width
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [EXP_W-1:0]     EXP_BIG  = {{(EXP_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

    logic [STAGES:1] vld_pipe;
    logic            stall;
    logic            accept;

    assign out_valid = vld_pipe[STAGES];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;

    // ---------------- S1: unpack and classify ----------------
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    kind_t            kind_d;

    assign ea     = a[W-2 -: EXP_W];
    assign eb     = b[W-2 -: EXP_W];
    assign fa     = a[MAN_W-1:0];
    assign fb     = b[MAN_W-1:0];
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_zero = (ea == '0);   // subnormals count as zero
    assign b_zero = (eb == '0);

    always_comb begin
        kind_d = K_NORM;
        if (a_nan | b_nan)
            kind_d = K_NAN;
        else if ((a_zero & b_inf) | (a_inf & b_zero))
            kind_d = K_NAN;
        else if (a_inf | b_inf)
            kind_d = K_INF;
        else if (a_zero | b_zero)
            kind_d = K_ZERO;
    end

    kind_t                  s1_kind, s2_kind;
    logic                   s1_sign, s2_sign;
    logic signed [EW-1:0]   s1_exp, s2_exp;
    logic        [MAN_W:0]  s1_ma, s1_mb;
    logic        [PW-1:0]   s2_prod;

    // ---------------- S3: normalise, round, pack ----------------
    logic        [PW-1:0]    norm;
    logic        [MAN_W-1:0] frac;
    logic                    guard, sticky, rnd_up, carry;
    logic        [MAN_W:0]   frac_r;
    logic signed [EW-1:0]    exp_n;
    logic        [W-1:0]     out_d;
    logic        [3:0]       flags_d;

    always_comb begin
        // Product of two [1,2) mantissas lies in [1,4); align so the leading one is at PW-1.
        norm   = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
        frac   = norm[PW-2 -: MAN_W];
        guard  = norm[PW-2-MAN_W];
        sticky = |norm[PW-3-MAN_W:0];
`ifdef FP_MULT_RNE_EN
        rnd_up = guard & (sticky | frac[0]);
`else
        rnd_up = 1'b0;
`endif
        frac_r = {1'b0, frac} + (MAN_W+1)'(rnd_up);
        // Carry out of the fraction means 1.11..1 rounded to 10.0: fraction is already 0.
        carry  = frac_r[MAN_W];
        exp_n  = s2_exp + EW'(s2_prod[PW-1]) + EW'(carry);

        out_d   = '0;
        flags_d = '0;
        case (s2_kind)
            K_NAN: begin
                out_d   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
                flags_d = 4'b1000;
            end
            K_INF:  out_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            K_ZERO: out_d = {s2_sign, {(W-1){1'b0}}};
            default: begin
                if (exp_n >= EXP_MAX) begin
`ifdef FP_MULT_RNE_EN
                    out_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
`else
                    out_d = {s2_sign, EXP_BIG, {MAN_W{1'b1}}};
`endif
                    flags_d = 4'b0101;
                end else if (exp_n <= 0) begin
                    out_d   = {s2_sign, {(W-1){1'b0}}};
                    flags_d = 4'b0011;
                end else begin
                    out_d   = {s2_sign, exp_n[EXP_W-1:0], frac_r[MAN_W-1:0]};
                    flags_d = {3'b000, guard | sticky};
                end
            end
        endcase
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            out      <= '0;
            flags    <= '0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            // S1
            s1_kind  <= kind_d;
            s1_sign  <= a[W-1] ^ b[W-1];
            s1_exp   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
            s1_ma    <= {1'b1, fa};
            s1_mb    <= {1'b1, fb};
            // S2
            s2_kind  <= s1_kind;
            s2_sign  <= s1_sign;
            s2_exp   <= s1_exp;
            s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
            // S3: only a real result replaces the held output
            if (vld_pipe[2]) begin
                out   <= out_d;
                flags <= flags_d;
            end
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
module tb_fp_mult_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, out;
    logic [3:0]  flags;

    int          n_cmp = 0, n_bad = 0, n_pop = 0;
    logic [35:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [35:0] prev_res = '0;

    always #5 clk = ~clk;

    fp_mult_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the real values, returns {flags, result}.
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int ex, ey, e, sh;
        logic s, xn, yn, xi, yi, xz, yz, inx;
        longint unsigned p, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        if (xn || yn) return {4'b1000, 32'h7FC00000};
        if ((xz && yi) || (xi && yz)) return {4'b1000, 32'h7FC00000};
        if (xi || yi) return {4'b0000, s, 8'hFF, 23'h0};
        if (xz || yz) return {4'b0000, s, 31'h0};
        p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
        e = ex + ey - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
        else sh = 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
`ifdef FP_MULT_RNE_EN
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
`endif
        if (e >= 255) begin
`ifdef FP_MULT_RNE_EN
            return {4'b0101, s, 8'hFF, 23'h0};
`else
            return {4'b0101, s, 8'hFE, 23'h7FFFFF};
`endif
        end
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, inx, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[30:23] = 8'h00;
            1: r[30:23] = 8'hFF;
            2: r[30:23] = 8'($urandom_range(100, 154));
            3: begin r[30:23] = 8'($urandom_range(110, 144)); r[11:0] = '0; end
            4: r[30:0] = {8'hFF, 23'h0};
            5: r[30:0] = '0;
            default: ;
        endcase
        return r;
    endfunction

    // Compare process: scoreboard, handshake rule and stall stability.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("stall_hold", {flags, out}, prev_res);
                check("stall_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("result", {flags, out}, exp_q.pop_front());
                    n_pop++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b));
            prev_stall = out_valid && !out_ready;
            prev_res   = {flags, out};
        end
    end

    task automatic run_one(input string nm, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] eo, input logic [3:0] ef);
        int lat;
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin @(posedge clk); #1 lat++; end
        check({nm, "_lat"}, lat, 3);
        check({nm, "_out"}, out, eo);
        check({nm, "_flags"}, flags, ef);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] hist;
        logic [31:0] ops_a[4], ops_b[4];
        int base, t;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_flags", flags, 0);
        check("rst_in_ready", in_ready, 1);

        run_one("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        run_one("mul_neg",   32'h40780000, 32'hC0600000, 32'hC1590000, 4'b0000);
        run_one("zero_inf",  32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        run_one("inf_inf",   32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000);
`ifdef FP_MULT_RNE_EN
        run_one("ovf",       32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        run_one("tie",       32'h3F800800, 32'h3F801800, 32'h3F802002, 4'b0001);
`else
        run_one("ovf",       32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 4'b0101);
        run_one("tie",       32'h3F800800, 32'h3F801800, 32'h3F802001, 4'b0001);
`endif
        run_one("unf",       32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
        run_one("nan_in",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_one("neg_zero",  32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
        run_one("daz_inf",   32'h00000001, 32'hFF800000, 32'h7FC00000, 4'b1000);

        // Back-to-back stream of 4, out_ready held high
        ops_a = '{32'h3FC00000, 32'h40780000, 32'h3F800800, rnd_op()};
        ops_b = '{32'h40000000, 32'hC0600000, 32'h3F801800, rnd_op()};
        a = ops_a[0]; b = ops_b[0]; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            hist[i] = out_valid;
            if (i < 3) begin a = ops_a[i+1]; b = ops_b[i+1]; end
            else in_valid = 1'b0;
        end
        check("stream_valid_run", hist, 8'h3C);

        // Backpressure: 3 ops, out_ready low for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = rnd_op(); b = rnd_op(); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_ready", in_ready, 0);
        end
        base = n_pop;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("bp_delivered", n_pop - base, 3);
        check("bp_drained_valid", out_valid, 0);

        // Reset while stalled
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = rnd_op(); b = rnd_op(); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 10) begin @(posedge clk); #1 t++; end
        check("rst_stall_reached", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_out", out, 0);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("rst_no_stale", out_valid, 0);
        end

        // Randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            a = rnd_op(); b = rnd_op();
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 check("final_drained", exp_q.size(), 0);
        check("final_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
